ball_game_ctrl: RTL and testbench

- Game sequencer for the ball datapath. It owns the frame tick, synchronises the player buttons and gates them into the ball position updater.
- It restarts the ball's x sweep, counts score and lives, and runs the IDLE/SERVE/PLAY/OVER flow.
- It sits between the raw board buttons / collision detector and the ball position block; the VGA renderer reads its status.

---
 rtl/ball_game_ctrl.sv | 108 ++++++++++
 tb/tb_ball_game_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl: game sequencer owning the movement tick, button syncs, score/lives and the IDLE/SERVE/PLAY/OVER flow.
module ball_game_ctrl #(
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60,
  parameter int X_END       = 460,
  parameter int LIVES_INIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       left_btn,
  input  logic       right_btn,
  input  logic       hit,
  input  logic [8:0] x_ball,
  output logic       move_en,
  output logic       left_en,
  output logic       right_en,
  output logic       ball_rst,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SERVE_TICKS + 1);
  localparam logic [8:0] XE = 9'(X_END);
  localparam logic [1:0] LI = 2'(LIVES_INIT);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  state_t state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] serve_cnt_q, serve_cnt_d;
  logic armed_q, armed_d, ball_rst_q, ball_rst_d;
  logic [1:0] l_sync_q, r_sync_q;
  logic [2:0] s_sync_q;
  logic tick, start_edge, past_end;
  always_comb begin
    tick = tick_cnt_q == TW'(TICK_DIV - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    start_edge = s_sync_q[1] & ~s_sync_q[2];
    past_end = x_ball >= XE;
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    serve_cnt_d = serve_cnt_q;
    ball_rst_d = 1'b0;
    // scoring rearms only once the ball is seen short of the end again
    armed_d = past_end ? armed_q : 1'b1;
    case (state_q)
      IDLE, OVER: if (start_edge) begin
        state_d = SERVE;
        score_d = '0;
        lives_d = LI;
        ball_rst_d = 1'b1;
        serve_cnt_d = '0;
      end
      SERVE: if (tick) begin
        serve_cnt_d = serve_cnt_q + 1'b1;
        state_d = serve_cnt_q == SW'(SERVE_TICKS - 1) ? PLAY : SERVE;
      end
      PLAY: if (hit) begin
        lives_d = lives_q - 1'b1;
        ball_rst_d = 1'b1;
        serve_cnt_d = '0;
        state_d = lives_q == 2'd1 ? OVER : SERVE;
      end else if (past_end && armed_q) begin
        score_d = score_q == 8'hff ? score_q : score_q + 1'b1;
        ball_rst_d = 1'b1;
        armed_d = 1'b0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      score_q <= '0;
      lives_q <= LI;
      tick_cnt_q <= '0;
      serve_cnt_q <= '0;
      armed_q <= 1'b1;
      ball_rst_q <= 1'b0;
      l_sync_q <= '0;
      r_sync_q <= '0;
      s_sync_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      tick_cnt_q <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      armed_q <= armed_d;
      ball_rst_q <= ball_rst_d;
      l_sync_q <= {l_sync_q[0], left_btn};
      r_sync_q <= {r_sync_q[0], right_btn};
      s_sync_q <= {s_sync_q[1:0], start_btn};
    end
  end
  assign move_en = tick & (state_q == PLAY);
  assign left_en = move_en & l_sync_q[1] & ~r_sync_q[1];
  assign right_en = move_en & r_sync_q[1] & ~l_sync_q[1];
  assign ball_rst = ball_rst_q;
  assign state = state_q;
  assign score = score_q;
  assign lives = lives_q;
  assign game_over = state_q == OVER;
endmodule

// File: tb/tb_ball_game_ctrl.sv
// tb_ball_game_ctrl: directed self-checking bench for ball_game_ctrl (TICK_DIV=4, SERVE_TICKS=2).
module tb_ball_game_ctrl;
  logic clk = 0, reset = 0, start_btn = 0, left_btn = 0, right_btn = 0, hit = 0;
  logic [8:0] x_ball = '0;
  logic move_en, left_en, right_en, ball_rst, game_over;
  logic [1:0] state, lives;
  logic [7:0] score;
  int checks = 0, failures = 0;
  int n_rst, n_serve, n_mv, n_l, n_r, n_bad;

  ball_game_ctrl #(.TICK_DIV(4), .SERVE_TICKS(2), .X_END(460), .LIVES_INIT(3)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .left_btn(left_btn),
    .right_btn(right_btn), .hit(hit), .x_ball(x_ball), .move_en(move_en),
    .left_en(left_en), .right_en(right_en), .ball_rst(ball_rst), .state(state),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s);
    for (int i = 0; i < 40 && state !== s; i++) @(negedge clk);
    chk(tag, int'(state), int'(s));
  endtask

  task automatic pulse_hit();
    hit = 1;
    step(1);
    hit = 0;
  endtask

  initial begin
    step(2);
    reset = 1;
    step(1);
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_ball_rst", ball_rst, 0);
    chk("rst_game_over", game_over, 0);
    n_mv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_mv += int'(move_en);
    end
    chk("idle_move_en", n_mv, 0);

    // 101 cycles after release: SERVE is entered on a tick boundary, so it lasts 8 cycles
    n_rst = 0; n_serve = 0; n_mv = 0;
    start_btn = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) start_btn = 0;
      n_rst += int'(ball_rst);
      n_serve += int'(state == 2'b01);
      n_mv += int'(move_en);
    end
    chk("start_ball_rst_count", n_rst, 1);
    chk("serve_cycles", n_serve, 8);
    chk("play_move_en_count", n_mv, 5);
    chk("play_state", state, 2);

    n_l = 0; n_r = 0; n_bad = 0;
    left_btn = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_l += int'(left_en);
      n_r += int'(right_en);
      n_bad += int'(left_en !== move_en);
    end
    chk("left_en_count", n_l, 5);
    chk("left_right_en_count", n_r, 0);
    chk("left_en_vs_move_en", n_bad, 0);

    right_btn = 1;
    step(4);
    n_l = 0; n_mv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_l += int'(left_en | right_en);
      n_mv += int'(move_en);
    end
    chk("both_btn_en_count", n_l, 0);
    chk("both_btn_move_en", n_mv, 5);
    left_btn = 0; right_btn = 0;
    step(4);

    x_ball = 9'd460;
    n_rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_rst += int'(ball_rst);
    end
    chk("score_pass1", score, 1);
    chk("ball_rst_pass1", n_rst, 1);
    x_ball = 9'd0;
    step(2);
    x_ball = 9'd470;
    n_rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_rst += int'(ball_rst);
    end
    chk("score_pass2", score, 2);
    chk("ball_rst_pass2", n_rst, 1);
    x_ball = 9'd0;
    step(2);
    for (int i = 0; i < 260; i++) begin
      x_ball = 9'd460;
      step(1);
      x_ball = 9'd0;
      step(1);
    end
    chk("score_saturate", score, 255);
    chk("state_after_passes", state, 2);

    pulse_hit();
    chk("hit1_state", state, 1);
    chk("hit1_lives", lives, 2);
    chk("hit1_ball_rst", ball_rst, 1);
    wait_state("hit1_back_to_play", 2'b10);
    pulse_hit();
    chk("hit2_state", state, 1);
    chk("hit2_lives", lives, 1);
    wait_state("hit2_back_to_play", 2'b10);
    pulse_hit();
    chk("hit3_state", state, 3);
    chk("hit3_lives", lives, 0);
    chk("hit3_game_over", game_over, 1);
    n_mv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_mv += int'(move_en | left_en | right_en);
    end
    chk("over_enables", n_mv, 0);
    chk("over_score_held", score, 255);

    start_btn = 1;
    step(3);
    start_btn = 0;
    step(1);
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);
    chk("restart_game_over", game_over, 0);
    wait_state("restart_play", 2'b10);

    x_ball = 9'd460;
    pulse_hit();
    x_ball = 9'd0;
    chk("hit_and_end_lives", lives, 2);
    chk("hit_and_end_score", score, 0);
    chk("hit_and_end_state", state, 1);

    reset = 0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_lives", lives, 3);
    chk("async_rst_ball_rst", ball_rst, 0);
    step(2);
    reset = 1;
    step(2);
    chk("post_rst_ball_rst", ball_rst, 0);
    chk("post_rst_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
